// File: rtl/bnn_pkg.sv
// Shared BNN types and constants: class count, score/index widths and argmax FSM states.
package bnn_pkg;

    localparam int unsigned N_CLASSES = 10;
    localparam int unsigned SCORE_W   = 5;
    localparam int unsigned IDX_W     = 4;

    typedef logic signed [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]          class_idx_t;
    typedef score_t [N_CLASSES-1:0]    score_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_e;

    localparam class_idx_t LAST_IDX = class_idx_t'(N_CLASSES - 1);

endpackage

// File: rtl/bnn_argmax_seq.sv
// Sequential argmax over the BNN class scores: one signed compare per clock,
// lowest index wins on equal scores, result offered on a valid/ready output.
module bnn_argmax_seq
    import bnn_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scores_valid_i,
    output logic       scores_ready_o,
    input  score_vec_t scores_i,
    output logic       result_valid_o,
    input  logic       result_ready_i,
    output class_idx_t class_o,
    output score_t     score_o,
    output logic       tie_o,
    output logic       busy_o
);

    argmax_state_e r_state;
    argmax_state_e w_next;

    score_vec_t r_scores;
    class_idx_t r_cnt;
    score_t     r_best;
    class_idx_t r_best_idx;
    logic       r_tie;

    score_t     w_cur;
    logic       w_last;

    assign w_cur  = r_scores[r_cnt];
    assign w_last = (r_cnt == LAST_IDX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        scores_ready_o = 1'b0;
        result_valid_o = 1'b0;
        busy_o         = 1'b0;
        case (r_state)
            IDLE: begin
                scores_ready_o = 1'b1;
                if (scores_valid_i) begin
                    w_next = SCAN;
                end
            end
            SCAN: begin
                busy_o = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                busy_o         = 1'b1;
                result_valid_o = 1'b1;
                if (result_ready_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_scores   <= '0;
            r_cnt      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_tie      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (scores_valid_i) begin
                        r_scores <= scores_i;
                        r_cnt    <= '0;
                    end
                end
                SCAN: begin
                    // Equal scores only raise the tie flag, so the earliest index is kept.
                    if (r_cnt == '0) begin
                        r_best     <= w_cur;
                        r_best_idx <= '0;
                        r_tie      <= 1'b0;
                    end else if (w_cur > r_best) begin
                        r_best     <= w_cur;
                        r_best_idx <= r_cnt;
                        r_tie      <= 1'b0;
                    end else if (w_cur == r_best) begin
                        r_tie <= 1'b1;
                    end
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign class_o = r_best_idx;
    assign score_o = r_best;
    assign tie_o   = r_tie;

endmodule
